// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: bus load/store, lane extension, misalignment, MEM/WB register
module mem_stage #(
  parameter logic [2:0] EXP_MISA = 3'h5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] fwd_data,
  input  logic [31:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  output logic        bus_req,
  input  logic        bus_grnt,
  output logic        bus_as,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy,
  output logic [31:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, HOLD} state_t;

  state_t      state, next_state;
  logic        is_word, is_half, is_byte, is_load, is_store, is_mem;
  logic        misaligned, access_pending, misa_hit;
  logic        start, done, load_en;
  logic [3:0]  be_c;
  logic [31:0] wr_data_c;
  logic [31:0] rd_src, load_data, result;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] hold_q;
  logic        flushed_q;

  // Decode the memory op, access size, alignment and lane placement of store data
  always_comb begin
    is_word    = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
    is_half    = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
    is_byte    = (ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU) || (ex_mem_op == OP_SB);
    is_load    = (ex_mem_op >= OP_LW) && (ex_mem_op <= OP_LBU);
    is_store   = (ex_mem_op >= OP_SW) && (ex_mem_op <= OP_SB);
    is_mem     = is_load || is_store;
    misaligned = (is_word && (ex_out[1:0] != 2'b00)) || (is_half && ex_out[0]);
    // An entry that already carries an exception never touches the bus
    access_pending = ex_en && is_mem && !misaligned && (ex_exp_code == 3'h0);
    misa_hit       = ex_en && is_mem && misaligned && (ex_exp_code == 3'h0);
    be_c = 4'h0;
    if (is_word)      be_c = 4'hF;
    else if (is_half) be_c = ex_out[1] ? 4'b1100 : 4'b0011;
    else if (is_byte) be_c = 4'b0001 << ex_out[1:0];
    wr_data_c = ex_mem_wr_data;
    if (is_byte)      wr_data_c = {4{ex_mem_wr_data[7:0]}};
    else if (is_half) wr_data_c = {2{ex_mem_wr_data[15:0]}};
  end

  // Select the addressed lane of the read data and extend it; HOLD replays the captured word
  always_comb begin
    rd_src = (state == HOLD) ? hold_q : bus_rd_data;
    case (ex_out[1:0])
      2'd0:    rd_byte = rd_src[7:0];
      2'd1:    rd_byte = rd_src[15:8];
      2'd2:    rd_byte = rd_src[23:16];
      default: rd_byte = rd_src[31:24];
    endcase
    rd_half = ex_out[1] ? rd_src[31:16] : rd_src[15:0];
    case (ex_mem_op)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'h0, rd_half};
      default: load_data = rd_src;
    endcase
    result   = (access_pending && is_load) ? load_data : ex_out;
    fwd_data = result;
  end

  // Bus access sequencer: next state, busy and the start/complete strobes
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (access_pending) begin
          busy       = 1'b1;
          start      = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus_grnt) next_state = ACCESS;
      end
      ACCESS: begin
        if (bus_rdy) begin
          done       = 1'b1;
          next_state = stall ? HOLD : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    load_en = !stall && !busy;
  end

  // State register, read-data hold register and the sticky flush seen during an access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_q    <= 32'h0;
      flushed_q <= 1'b0;
    end else begin
      state <= next_state;
      if (done) hold_q <= bus_rd_data;
      if (load_en)                                 flushed_q <= 1'b0;
      else if (flush && (busy || state == HOLD))   flushed_q <= 1'b1;
    end
  end

  // Registered bus outputs: launched on entry to REQ, cleared when the access completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req     <= 1'b0;
      bus_as      <= 1'b0;
      bus_rw      <= 1'b0;
      bus_addr    <= 30'h0;
      bus_be      <= 4'h0;
      bus_wr_data <= 32'h0;
    end else begin
      bus_as <= (state == REQ) && bus_grnt;
      if (start) begin
        bus_req     <= 1'b1;
        bus_rw      <= is_load;
        bus_addr    <= ex_out[31:2];
        bus_be      <= be_c;
        bus_wr_data <= is_store ? wr_data_c : 32'h0;
      end else if (done) begin
        bus_req     <= 1'b0;
        bus_rw      <= 1'b0;
        bus_addr    <= 30'h0;
        bus_be      <= 4'h0;
        bus_wr_data <= 32'h0;
      end
    end
  end

  // MEM/WB register: flush (now or remembered from the access) invalidates, else load when free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_pc       <= 32'h0;
      mem_en       <= 1'b0;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= 2'h0;
      mem_dst_addr <= 5'h0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= 3'h0;
      mem_out      <= 32'h0;
    end else if (flush || (flushed_q && load_en)) begin
      mem_en       <= 1'b0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= 3'h0;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= 2'h0;
    end else if (load_en) begin
      mem_pc       <= ex_pc;
      mem_en       <= ex_en;
      mem_br_flag  <= ex_br_flag;
      mem_ctrl_op  <= ex_ctrl_op;
      mem_dst_addr <= ex_dst_addr;
      mem_gpr_we_  <= (!ex_en || misa_hit) ? 1'b1 : ex_gpr_we_;
      mem_exp_code <= misa_hit ? EXP_MISA : ex_exp_code;
      mem_out      <= result;
    end
  end

endmodule
